// File: rtl/tlb_op_ctrl.sv
// tlb_op_ctrl
// Sequences committed TLB maintenance instructions (TLBSRCH, TLBRD, TLBWR,
// TLBFILL, INVTLB) against a TLBNUM-entry TLB and signals completion so
// writeback can issue the refetch.
//
// Ports
//   clk, resetn              clock, asynchronous active-low reset
//   req_valid/req_ready      committed instruction handshake (ready == idle)
//   req_op, req_inv_*        opcode and INVTLB operands, latched on accept
//   csr_*                    live CSR values, read during the action cycle
//   s_*                      TLB search port (TLBSRCH)
//   r_*                      TLB read port (TLBRD and the INVTLB scan)
//   we, w_*                  TLB write port (TLBWR / TLBFILL)
//   c_we, c_index            clear the E bit of one entry (INVTLB)
//   srch_we/hit/index        TLBIDX update for TLBSRCH, driven in FIN
//   rd_we                    CSR file captures read-port data
//   done, err                one-cycle completion pulse, error qualifier
module tlb_op_ctrl #(
  parameter int TLBNUM = 16,
  parameter int IDXW   = 4
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [4:0]      req_inv_op,
  input  logic [9:0]      req_inv_asid,
  input  logic [31:0]     req_inv_va,
  input  logic [31:0]     csr_tlbidx,
  input  logic [31:0]     csr_tlbehi,
  input  logic [31:0]     csr_tlbelo0,
  input  logic [31:0]     csr_tlbelo1,
  input  logic [31:0]     csr_asid,
  output logic [18:0]     s_vppn,
  output logic [9:0]      s_asid,
  input  logic            s_found,
  input  logic [IDXW-1:0] s_index,
  output logic [IDXW-1:0] r_index,
  input  logic            r_e,
  input  logic            r_g,
  input  logic [18:0]     r_vppn,
  input  logic [5:0]      r_ps,
  input  logic [9:0]      r_asid,
  output logic            we,
  output logic [IDXW-1:0] w_index,
  output logic            w_e,
  output logic            w_g,
  output logic            w_d0,
  output logic            w_v0,
  output logic            w_d1,
  output logic            w_v1,
  output logic [18:0]     w_vppn,
  output logic [5:0]      w_ps,
  output logic [9:0]      w_asid,
  output logic [19:0]     w_ppn0,
  output logic [19:0]     w_ppn1,
  output logic [1:0]      w_plv0,
  output logic [1:0]      w_mat0,
  output logic [1:0]      w_plv1,
  output logic [1:0]      w_mat1,
  output logic            c_we,
  output logic [IDXW-1:0] c_index,
  output logic            srch_we,
  output logic            srch_hit,
  output logic [IDXW-1:0] srch_index,
  output logic            rd_we,
  output logic            done,
  output logic            err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SRCH = 3'd1,
    S_RD   = 3'd2,
    S_WR   = 3'd3,
    S_INV  = 3'd4,
    S_FIN  = 3'd5
  } state_t;

  localparam logic [IDXW-1:0] IDX_ONE  = {{(IDXW-1){1'b0}}, 1'b1};
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(TLBNUM - 1);

  state_t          state_reg, state_next;
  logic            is_srch_reg, is_fill_reg, err_reg;
  logic [2:0]      inv_op_reg;
  logic [9:0]      inv_asid_reg;
  logic [18:0]     inv_vppn_reg;        // va[31:13]
  logic [IDXW-1:0] fill_cnt_reg;        // free-running replacement counter
  logic [IDXW-1:0] fill_idx_reg;        // counter value sampled at accept
  logic [IDXW-1:0] scan_reg;            // INVTLB entry pointer
  logic            srch_hit_reg;
  logic [IDXW-1:0] srch_idx_reg;

  logic accept;
  logic op_bad;
  logic va_match, asid_match, inv_match;

  assign accept = (state_reg == S_IDLE) && req_valid;
  assign op_bad = (req_op > 3'd4) || ((req_op == 3'd4) && (req_inv_op > 5'd6));

  // ---------------------------------------------------------------- state
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // -------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      is_srch_reg  <= 1'b0;
      is_fill_reg  <= 1'b0;
      err_reg      <= 1'b0;
      inv_op_reg   <= 3'd0;
      inv_asid_reg <= 10'd0;
      inv_vppn_reg <= 19'd0;
      fill_cnt_reg <= '0;
      fill_idx_reg <= '0;
      scan_reg     <= '0;
      srch_hit_reg <= 1'b0;
      srch_idx_reg <= '0;
    end else begin
      fill_cnt_reg <= fill_cnt_reg + IDX_ONE;
      if (accept) begin
        is_srch_reg  <= (req_op == 3'd0);
        is_fill_reg  <= (req_op == 3'd3);
        err_reg      <= op_bad;
        inv_op_reg   <= req_inv_op[2:0];
        inv_asid_reg <= req_inv_asid;
        inv_vppn_reg <= req_inv_va[31:13];
        fill_idx_reg <= fill_cnt_reg;
      end
      // Counter wraps to zero after the last entry, ready for the next scan.
      if (state_reg == S_INV) begin
        scan_reg <= scan_reg + IDX_ONE;
      end
      if (state_reg == S_SRCH) begin
        srch_hit_reg <= s_found;
        srch_idx_reg <= s_found ? s_index : '0;
      end
    end
  end

  // --------------------------------------------------------- INVTLB match
  // A 2MB page (ps 21) only carries significant VPPN bits above bit 21.
  assign va_match   = (r_ps == 6'd21) ? (r_vppn[18:9] == inv_vppn_reg[18:9])
                                      : (r_vppn == inv_vppn_reg);
  assign asid_match = (r_asid == inv_asid_reg);

  always_comb begin
    inv_match = 1'b0;
    case (inv_op_reg)
      3'd0, 3'd1: inv_match = 1'b1;
      3'd2:       inv_match = r_g;
      3'd3:       inv_match = ~r_g;
      3'd4:       inv_match = ~r_g & asid_match;
      3'd5:       inv_match = ~r_g & asid_match & va_match;
      3'd6:       inv_match = (r_g | asid_match) & va_match;
      default:    inv_match = 1'b0;
    endcase
  end

  // ---------------------------------------------- next state and strobes
  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    r_index    = '0;
    we         = 1'b0;
    c_we       = 1'b0;
    c_index    = '0;
    srch_we    = 1'b0;
    srch_hit   = 1'b0;
    srch_index = '0;
    rd_we      = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    case (state_reg)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (op_bad) begin
            state_next = S_FIN;
          end else begin
            case (req_op)
              3'd0:       state_next = S_SRCH;
              3'd1:       state_next = S_RD;
              3'd2, 3'd3: state_next = S_WR;
              default:    state_next = S_INV;
            endcase
          end
        end
      end
      S_SRCH: state_next = S_FIN;
      S_RD: begin
        r_index    = csr_tlbidx[IDXW-1:0];
        rd_we      = 1'b1;
        state_next = S_FIN;
      end
      S_WR: begin
        we         = 1'b1;
        state_next = S_FIN;
      end
      S_INV: begin
        r_index = scan_reg;
        c_index = scan_reg;
        c_we    = inv_match & r_e;
        if (scan_reg == IDX_LAST) begin
          state_next = S_FIN;
        end
      end
      S_FIN: begin
        done       = 1'b1;
        err        = err_reg;
        srch_we    = is_srch_reg;
        srch_hit   = is_srch_reg & srch_hit_reg;
        srch_index = is_srch_reg ? srch_idx_reg : '0;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------- port field mapping
  assign s_vppn = csr_tlbehi[31:13];
  assign s_asid = csr_asid[9:0];

  assign w_index = is_fill_reg ? fill_idx_reg : csr_tlbidx[IDXW-1:0];
  assign w_e     = ~csr_tlbidx[31];        // NE bit inverted
  assign w_ps    = csr_tlbidx[29:24];
  assign w_vppn  = csr_tlbehi[31:13];
  assign w_asid  = csr_asid[9:0];
  assign w_g     = csr_tlbelo0[6] & csr_tlbelo1[6];

  // Per-page fields of the even (0) and odd (1) halves.
  logic [31:0] elo   [2];
  logic [19:0] ppn_w [2];
  logic [1:0]  plv_w [2];
  logic [1:0]  mat_w [2];
  logic        d_w   [2];
  logic        v_w   [2];

  assign elo[0] = csr_tlbelo0;
  assign elo[1] = csr_tlbelo1;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_page
      assign ppn_w[gi] = elo[gi][27:8];
      assign plv_w[gi] = elo[gi][3:2];
      assign mat_w[gi] = elo[gi][5:4];
      assign d_w[gi]   = elo[gi][1];
      assign v_w[gi]   = elo[gi][0];
    end
  endgenerate

  assign w_ppn0 = ppn_w[0];
  assign w_ppn1 = ppn_w[1];
  assign w_plv0 = plv_w[0];
  assign w_plv1 = plv_w[1];
  assign w_mat0 = mat_w[0];
  assign w_mat1 = mat_w[1];
  assign w_d0   = d_w[0];
  assign w_d1   = d_w[1];
  assign w_v0   = v_w[0];
  assign w_v1   = v_w[1];

endmodule

// File: doc/tlb_op_ctrl.md
# tlb_op_ctrl

Sequences the TLB maintenance instructions (TLBSRCH, TLBRD, TLBWR, TLBFILL, INVTLB) against the 16-entry TLB once they commit in writeback. It owns the TLB search, read, write and entry-clear ports for maintenance use. It walks INVTLB over every entry one per cycle and generates the TLBFILL replacement index. It reports results to the CSR file and signals completion so writeback can issue the refetch.

## Interface
- TLBNUM, 16, TLB entry count (power of two)
- IDXW, 4, index width = log2(TLBNUM)

- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- req_valid  in  1  committed TLB instruction present
- req_ready  out  1  controller idle, request accepted this cycle if req_valid
- req_op  in  3  0 SRCH, 1 RD, 2 WR, 3 FILL, 4 INV; 5-7 reserved
- req_inv_op  in  5  INVTLB op field
- req_inv_asid  in  10  INVTLB rj[9:0]
- req_inv_va  in  32  INVTLB rk
- csr_tlbidx, csr_tlbehi, csr_tlbelo0, csr_tlbelo1, csr_asid  in  32 each  current CSR values
- s_vppn  out  19; s_asid  out  10; s_found  in  1; s_index  in  IDXW  search port
- r_index  out  IDXW; r_e, r_g  in  1; r_vppn  in  19; r_ps  in  6; r_asid  in  10  read port
- we  out  1; w_index  out  IDXW; w_e, w_g, w_d0, w_v0, w_d1, w_v1  out  1; w_vppn  out  19; w_ps  out  6; w_asid  out  10; w_ppn0, w_ppn1  out  20; w_plv0, w_mat0, w_plv1, w_mat1  out  2  write port
- c_we  out  1; c_index  out  IDXW  clear E bit of one entry
- srch_we  out  1; srch_hit  out  1; srch_index  out  IDXW  TLBIDX update for TLBSRCH
- rd_we  out  1  CSR file captures read-port data into TLBEHI/ELO0/ELO1/IDX.PS/ASID
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done: reserved req_op or INVTLB op > 6

## Operation
- States: IDLE, SRCH, RD, WR, INV, FIN. req_ready = (state==IDLE). Operands latched on accept.
- SRCH: s_vppn=csr_tlbehi[31:13], s_asid=csr_asid[9:0]; s_found/s_index sampled at end of SRCH → srch_we=1, srch_hit=s_found, srch_index (0 on miss) driven in FIN.
- RD: r_index=csr_tlbidx[IDXW-1:0]; rd_we=1 in RD cycle.
- WR: we=1 for one cycle. w_index = csr_tlbidx[IDXW-1:0] for WR, latched fill_idx for FILL. w_e=~tlbidx[31], w_ps=tlbidx[29:24], w_vppn=tlbehi[31:13], w_asid=asid[9:0], w_g=elo0[6]&elo1[6], w_ppnN=eloN[27:8], w_plvN=eloN[3:2], w_matN=eloN[5:4], w_dN=eloN[1], w_vN=eloN[0].
- fill_idx: IDXW-bit counter, +1 every cycle, wraps; value sampled at accept.
- INV: scan counter k=0..TLBNUM-1, one entry per cycle; r_index=k; c_we=match&r_e, c_index=k same cycle. VA match: r_ps==21 compares r_vppn[18:9] vs va[31:22]; otherwise r_vppn vs va[31:13]. ASID match: r_asid==inv_asid. match by op: 0,1 all; 2 r_g; 3 ~r_g; 4 ~r_g&asid; 5 ~r_g&asid&va; 6 (r_g|asid)&va.
- Invalid op (req_op 5-7 or inv_op>6): IDLE→FIN directly, no port activity, err=1.
- FIN: done=1, then IDLE. All strobes (we, c_we, srch_we, rd_we, done, err) zero outside their states.

## Timing
- Accept at cycle 0. SRCH/RD/WR/FILL: action in cycle 1, done in cycle 2. INV: entries 0..15 in cycles 1..16, done in cycle 17. Invalid: done+err in cycle 1.
- New request accepted in the cycle after done (IDLE); req_valid while busy is ignored and not queued.
- CSR inputs read live during the action cycle. The CSR file does not change them while busy.
- Reset (any state, asynchronous): state IDLE, req_ready=1, scan counter 0, fill_idx 0, every strobe/result output 0. Reset mid-INV abandons the scan; already-cleared entries stay cleared.

## Test plan
- TLBWR, tlbidx=0x0C00_0005 (PS=12, NE=0), ehi=0x1234_6000 → cycle 1: we=1, w_index=5, w_e=1, w_vppn=0x091A3, w_ps=12; done cycle 2.
- TLBSRCH hit (s_found=1, s_index=9) → srch_we/srch_hit=1, srch_index=9 in FIN; repeat with miss → srch_hit=0, srch_index=0.
- INVTLB op 5, asid=3, va=0x0040_0000; entries 2 (g=0, asid 3, vppn 0x00200, ps 12) and 7 (same but g=1) valid → c_we only at k=2, done at cycle 17.
- INVTLB op 0 with all entries valid → c_we on 16 consecutive cycles, indices 0..15; ps=21 entry matching only in vppn[18:9] cleared by op 6.
- TLBFILL accepted 20 cycles after reset → w_index=20 mod 16=4; back-to-back FILL 3 cycles later → index 7.
- req_op=6 → done=1, err=1 in cycle 1, no we/c_we; resetn low at INV k=8 → outputs 0 at once, req_ready=1, entries 8-15 untouched.
